alarm_scheduler: RTL and testbench
==================================

# alarm_scheduler

Sequencing and sharing controller for the 32-bit free-running counter. It drives the counter's enable and shares the one counter value among NUM_CH requesters, each of which can arm a one-shot (or optionally periodic) alarm relative to the current count. Arm requests go through round-robin arbitration into a single shared deadline adder. Expiries are reported as a one-cycle fire pulse plus a sticky pending flag cleared by acknowledge. Sits beside the counter instance; requesters are the timekeeping clients of the clock subsystem.

## Interface
- NUM_CH, 4, number of alarm channels (2..8)
- i_clk  in  1  system clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_run  in  1  counter run request
- o_cnt_enable  out  1  registered i_run, wired to the counter's i_enable
- i_count  in  32  counter value o_count
- i_arm_valid  in  NUM_CH  per-channel arm request
- i_arm_delta  in  NUM_CH*32  per-channel delta, channel n at [32n+31:32n]
- o_arm_ready  out  NUM_CH  one-hot grant; a request is accepted when valid & ready
- i_disarm  in  NUM_CH  cancel the armed alarm (level, sampled each edge)
- o_fire  out  NUM_CH  one-cycle expiry pulse
- o_pending  out  NUM_CH  sticky expiry flag
- i_ack  in  NUM_CH  clears pending
- o_armed  out  NUM_CH  channel holds a live deadline

## Operation
- Reset: o_cnt_enable=0, o_fire=0, o_pending=0, o_armed=0, RR pointer=0, all deadlines=0.
- Per-channel states: IDLE, ARMED. IDLE→ARMED on accept; ARMED→IDLE on expiry or disarm.
- Arbitration: o_arm_ready is combinational from i_arm_valid and the RR pointer. It grants the first valid channel at or after the pointer. After a grant the pointer moves to grant+1 mod NUM_CH. At most one accept per cycle. Requesters hold valid and delta until ready.
- Delta clamp: 0→1; values ≥2^31→2^31−1.
- Deadline D = i_count + delta mod 2^32, with i_count sampled in the accept cycle.
- Expiry test: (i_count − D) taken as signed 32-bit ≥ 0. This is wrap-safe across 0xFFFFFFFF→0.
- Counter stopped (o_cnt_enable=0): deadlines hold and no new expiries occur unless already satisfied.
- Arming an ARMED channel replaces its deadline and does not fire the old one.
- Same-cycle conflicts:
  - Disarm and accept on the same channel: disarm wins and the channel ends IDLE; the request is still consumed.
  - Disarm and expiry: disarm wins, no fire.
  - Ack and new fire: pending stays 1.

## Timing
- o_cnt_enable follows i_run with a 1-cycle delay.
- Accept at edge k → o_armed=1 from edge k.
- Expiry condition true during cycle j → o_fire high and o_pending set from edge j+1, for exactly one cycle. o_armed drops at the same edge (one-shot).
- Delta=1 accepted while counting: count reaches D one edge later, so o_fire appears 2 cycles after accept.
- i_ack sampled at an edge clears pending at that edge.
- Reset mid-operation: all state is cleared immediately. A fire pulse in progress is truncated.

## Configuration
- ALARM_PERIODIC_EN defined:
  - Adds input i_arm_periodic [NUM_CH], sampled at accept, and a per-channel stored delta.
  - On expiry a periodic channel stays ARMED with D_next = D + delta, computed from the old deadline so no drift accumulates. The same fire/pending behaviour applies.
  - Disarm stops it.
- Not defined: the port and the stored delta are absent, and all alarms are one-shot.

## Structure
- Package alarm_sched_pkg holds:
  - COUNT_W=32
  - MAX_DELTA=32'h7FFF_FFFF
  - the channel state enum (IDLE, ARMED)
  - a delta clamp function
- Sub-module alarm_rr_arbiter: parameterized NUM_CH round-robin grant with pointer register. Combinational grant, registered pointer advance.
- Per-channel deadline registers and comparators live in the top level, generated per channel. There is one shared adder after the grant mux.

## Test plan
- Reset then i_run=1 → o_cnt_enable=1 one cycle later; all other outputs stay 0 throughout reset.
- Ch0 arms delta=10 at count 100 → o_fire[0] pulses once when the count reaches 110 (next edge); o_pending[0]=1 until i_ack[0].
- i_count near 0xFFFFFFF0, delta=0x20 → fires after the wrap at count 0x10, not before.
- All channels valid simultaneously → grants in order 0,1,2,3, one per cycle; the pointer then continues from 0 with no starvation.
- Disarm on the same cycle as the expiry → no fire, o_armed=0. Ack coinciding with a re-fire → o_pending stays 1.
- With ALARM_PERIODIC_EN, period 5 → fires at D, D+5, D+10 with exact spacing, including across i_run toggling off and back on.

Source files
------------

// File: rtl/alarm_sched_pkg.sv
// Shared constants, channel state and delta clamp for alarm_scheduler.
package alarm_sched_pkg;

    localparam int COUNT_W = 32;
    localparam logic [COUNT_W-1:0] MAX_DELTA = 32'h7FFF_FFFF;

    typedef enum logic {
        IDLE,
        ARMED
    } ch_state_e;

    // Keep deltas inside the signed half-range so the expiry test stays wrap-safe.
    function automatic logic [COUNT_W-1:0] clamp_delta(input logic [COUNT_W-1:0] d);
        if (d == '0) begin
            return 32'd1;
        end
        if (d[COUNT_W-1]) begin
            return MAX_DELTA;
        end
        return d;
    endfunction

endpackage

// File: rtl/alarm_rr_arbiter.sv
// Round-robin grant: combinational one-hot grant, registered pointer.
module alarm_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int PW     = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [NUM_CH-1:0] i_req,
    output logic [NUM_CH-1:0] o_grant,
    output logic [PW-1:0]     o_gnt_idx
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        o_grant   = '0;
        o_gnt_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = PW'((int'(ptr_q) + i) % NUM_CH);
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                o_gnt_idx    = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (o_gnt_idx == PW'(NUM_CH - 1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Shares one 32-bit counter among NUM_CH alarm channels via a single deadline adder.
// Define ALARM_PERIODIC_EN for periodic (drift-free reload) alarms.
module alarm_scheduler
    import alarm_sched_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_run,
    output logic                      o_cnt_enable,
    input  logic [COUNT_W-1:0]        i_count,
    input  logic [NUM_CH-1:0]         i_arm_valid,
    input  logic [NUM_CH*COUNT_W-1:0] i_arm_delta,
`ifdef ALARM_PERIODIC_EN
    input  logic [NUM_CH-1:0]         i_arm_periodic,
`endif
    output logic [NUM_CH-1:0]         o_arm_ready,
    input  logic [NUM_CH-1:0]         i_disarm,
    output logic [NUM_CH-1:0]         o_fire,
    output logic [NUM_CH-1:0]         o_pending,
    input  logic [NUM_CH-1:0]         i_ack,
    output logic [NUM_CH-1:0]         o_armed
);

    localparam int PW = $clog2(NUM_CH);

    logic               run_q, run_d;
    logic [PW-1:0]      gnt_idx;
    logic [COUNT_W-1:0] arm_delta;
    logic [COUNT_W-1:0] arm_deadline;

    alarm_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PW     (PW)
    ) u_arb (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_req     (i_arm_valid),
        .o_grant   (o_arm_ready),
        .o_gnt_idx (gnt_idx)
    );

    assign run_d        = i_run;
    assign o_cnt_enable = run_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    assign arm_delta    = clamp_delta(i_arm_delta[gnt_idx*COUNT_W +: COUNT_W]);
    assign arm_deadline = i_count + arm_delta;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        ch_state_e          state_q, state_d;
        logic [COUNT_W-1:0] dl_q, dl_d;
        logic [COUNT_W-1:0] diff;
        logic               fire_q, fire_d;
        logic               pend_q, pend_d;
        logic               expire;
`ifdef ALARM_PERIODIC_EN
        logic               per_q, per_d;
        logic [COUNT_W-1:0] dlt_q, dlt_d;
`endif

        assign diff   = i_count - dl_q;
        assign expire = (state_q == ARMED) && !diff[COUNT_W-1];

        // Priority: disarm, then a new arm (drops the old deadline), then expiry.
        always_comb begin
            state_d = state_q;
            dl_d    = dl_q;
            fire_d  = 1'b0;
`ifdef ALARM_PERIODIC_EN
            per_d   = per_q;
            dlt_d   = dlt_q;
`endif
            if (i_disarm[n]) begin
                state_d = IDLE;
            end else if (o_arm_ready[n]) begin
                state_d = ARMED;
                dl_d    = arm_deadline;
`ifdef ALARM_PERIODIC_EN
                per_d   = i_arm_periodic[n];
                dlt_d   = arm_delta;
`endif
            end else if (expire) begin
                fire_d  = 1'b1;
`ifdef ALARM_PERIODIC_EN
                if (per_q) begin
                    dl_d = dl_q + dlt_q;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            pend_d = fire_d | (pend_q & ~i_ack[n]);
        end

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                state_q <= IDLE;
                dl_q    <= '0;
                fire_q  <= 1'b0;
                pend_q  <= 1'b0;
`ifdef ALARM_PERIODIC_EN
                per_q   <= 1'b0;
                dlt_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                dl_q    <= dl_d;
                fire_q  <= fire_d;
                pend_q  <= pend_d;
`ifdef ALARM_PERIODIC_EN
                per_q   <= per_d;
                dlt_q   <= dlt_d;
`endif
            end
        end

        assign o_fire[n]    = fire_q;
        assign o_pending[n] = pend_q;
        assign o_armed[n]   = (state_q == ARMED);
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with a behavioural free-running counter.
module tb_alarm_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           run = 1'b0;
    logic [31:0]    count = '0;
    logic [N-1:0]   valid = '0;
    logic [N-1:0]   disarm = '0;
    logic [N-1:0]   ack = '0;
    logic [N*32-1:0] delta = '0;
`ifdef ALARM_PERIODIC_EN
    logic [N-1:0]   periodic = '0;
`endif
    logic           cnt_en;
    logic [N-1:0]   ready, fire, pend, armed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] disarm;
        logic [N-1:0] ready;
        logic [N-1:0] armed;
    } vec_t;

    vec_t tbl [11];

    alarm_scheduler #(.NUM_CH(N)) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_run          (run),
        .o_cnt_enable   (cnt_en),
        .i_count        (count),
        .i_arm_valid    (valid),
        .i_arm_delta    (delta),
`ifdef ALARM_PERIODIC_EN
        .i_arm_periodic (periodic),
`endif
        .o_arm_ready    (ready),
        .i_disarm       (disarm),
        .o_fire         (fire),
        .o_pending      (pend),
        .i_ack          (ack),
        .o_armed        (armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Counter model: increments at an edge when enable was high before it.
    task automatic tick();
        logic e;
        e = cnt_en;
        @(posedge clk);
        @(negedge clk);
        if (e === 1'b1) count = count + 1;
    endtask

    task automatic set_delta(input int ch, input logic [31:0] d);
        delta[32*ch +: 32] = d;
    endtask

    task automatic wait_fire(input int ch, input int budget,
                             output int nf, output logic [31:0] at);
        logic [31:0] pre;
        nf = 0;
        at = '1;
        for (int i = 0; i < budget; i++) begin
            pre = count;
            tick();
            if (fire[ch]) begin
                if (nf == 0) at = pre;
                nf++;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int          nf;
        logic [31:0] at;
        logic [31:0] dd;

        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0011};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0111};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b1111};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b1111};
        tbl[5]  = '{4'b1010, 4'b0000, 4'b0010, 4'b1111};
        tbl[6]  = '{4'b1010, 4'b0000, 4'b1000, 4'b1111};
        tbl[7]  = '{4'b1010, 4'b0000, 4'b0010, 4'b1111};
        tbl[8]  = '{4'b0000, 4'b0101, 4'b0000, 4'b1010};
        tbl[9]  = '{4'b0001, 4'b0001, 4'b0001, 4'b1010};
        tbl[10] = '{4'b0000, 4'b1010, 4'b0000, 4'b0000};

        // Reset behaviour and enable latency
        @(negedge clk);
        run = 1'b1;
        repeat (3) tick();
        chk("rst_cnt_en", 32'(cnt_en), 0);
        chk("rst_fire", 32'(fire), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_armed", 32'(armed), 0);
        rstn = 1'b1;
        #1 chk("en_before_edge", 32'(cnt_en), 0);
        tick();
        chk("en_after_edge", 32'(cnt_en), 1);

        // Basic one-shot: delta 10 at count 100
        count = 100;
        set_delta(0, 10);
        valid = 4'b0001;
        #1 chk("a_ready", 32'(ready), 32'b0001);
        tick();
        valid = '0;
        chk("a_armed", 32'(armed), 32'b0001);
        wait_fire(0, 20, nf, at);
        chk("a_nfire", nf, 1);
        chk("a_fire_at", at, 110);
        chk("a_pend", 32'(pend), 32'b0001);
        chk("a_armed_off", 32'(armed), 0);
        tick();
        tick();
        chk("a_pend_hold", 32'(pend), 32'b0001);
        ack = 4'b0001;
        tick();
        ack = '0;
        chk("a_pend_clr", 32'(pend), 0);

        // Wrap across 0xFFFFFFFF
        count = 32'hFFFF_FFF0;
        set_delta(1, 32'h20);
        valid = 4'b0010;
        #1 chk("w_ready", 32'(ready), 32'b0010);
        tick();
        valid = '0;
        wait_fire(1, 40, nf, at);
        chk("w_nfire", nf, 1);
        chk("w_fire_at", at, 32'h10);
        ack = 4'b0010;
        tick();
        ack = '0;

        // Delta 0 clamps to 1: fire two cycles after accept
        count = 500;
        set_delta(2, 0);
        valid = 4'b0100;
        #1 chk("z_ready", 32'(ready), 32'b0100);
        tick();
        valid = '0;
        tick();
        chk("z_fire", 32'(fire), 32'b0100);
        chk("z_pend", 32'(pend), 32'b0100);
        ack = 4'b0100;
        tick();
        ack = '0;

        // Huge delta clamps to 2^31-1: never fires soon
        set_delta(3, 32'hFFFF_FFFF);
        valid = 4'b1000;
        #1 chk("h_ready", 32'(ready), 32'b1000);
        tick();
        valid = '0;
        wait_fire(3, 8, nf, at);
        chk("h_nfire", nf, 0);
        chk("h_armed", 32'(armed), 32'b1000);
        disarm = 4'b1000;
        tick();
        disarm = '0;
        chk("h_disarm", 32'(armed), 0);

        // Disarm coinciding with expiry
        count = 1000;
        set_delta(0, 5);
        valid = 4'b0001;
        tick();
        valid = '0;
        nf = 0;
        for (int i = 0; i < 10; i++) begin
            disarm = (count == 1005) ? 4'b0001 : 4'b0000;
            tick();
            if (fire[0]) nf++;
        end
        disarm = '0;
        chk("d_nfire", nf, 0);
        chk("d_armed", 32'(armed), 0);
        chk("d_pend", 32'(pend), 0);

        // Ack coinciding with a re-fire keeps pending
        count = 2000;
        set_delta(1, 2);
        valid = 4'b0010;
        tick();
        valid = '0;
        wait_fire(1, 4, nf, at);
        chk("r_first_fire", nf, 1);
        dd = count + 2;
        valid = 4'b0010;
        #1 chk("r_ready", 32'(ready), 32'b0010);
        tick();
        valid = '0;
        tick();
        chk("r_no_early", 32'(fire), 0);
        chk("r_cnt_at_d", count, dd);
        ack = 4'b0010;
        tick();
        chk("r_refire", 32'(fire), 32'b0010);
        chk("r_pend_kept", 32'(pend), 32'b0010);
        tick();
        ack = '0;
        chk("r_pend_clr", 32'(pend), 0);
        chk("r_fire_one", 32'(fire), 0);

        // Reset during a fire pulse
        for (int c = 0; c < N; c++) set_delta(c, 1);
        valid = '1;
        tick();
        valid = '0;
        tick();
        chk("x_fire_live", 32'(fire != 0), 1);
        rstn = 1'b0;
        #1;
        chk("x_fire_cut", 32'(fire), 0);
        chk("x_pend_cut", 32'(pend), 0);
        chk("x_armed_cut", 32'(armed), 0);
        chk("x_en_cut", 32'(cnt_en), 0);
        tick();
        rstn = 1'b1;
        tick();

        // Arbitration table
        for (int c = 0; c < N; c++) set_delta(c, 1000);
        count = 3000;
        for (int i = 0; i < 11; i++) begin
            valid  = tbl[i].valid;
            disarm = tbl[i].disarm;
            #1 chk($sformatf("t%0d_ready", i), 32'(ready), 32'(tbl[i].ready));
            tick();
            chk($sformatf("t%0d_armed", i), 32'(armed), 32'(tbl[i].armed));
            chk($sformatf("t%0d_fire", i), 32'(fire), 0);
        end
        valid  = '0;
        disarm = '0;

        // Run toggle
        run = 1'b0;
        tick();
        chk("run_off", 32'(cnt_en), 0);
        run = 1'b1;
        tick();
        chk("run_on", 32'(cnt_en), 1);

`ifdef ALARM_PERIODIC_EN
        // Periodic: spacing exact across a run pause
        count = 4000;
        set_delta(1, 5);
        periodic = 4'b0010;
        valid = 4'b0010;
        #1 chk("p_ready", 32'(ready), 32'b0010);
        tick();
        valid = '0;
        periodic = '0;
        nf = 0;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] pre;
            if (i == 8)  run = 1'b0;
            if (i == 13) run = 1'b1;
            pre = count;
            tick();
            if (fire[1]) begin
                chk($sformatf("p_fire%0d_at", nf), pre, 32'(4005 + 5 * nf));
                nf++;
            end
        end
        chk("p_nfire_ge3", 32'(nf >= 3), 1);
        chk("p_armed", 32'(armed), 32'b0010);
        disarm = 4'b0010;
        tick();
        disarm = '0;
        chk("p_disarm", 32'(armed), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
